// File: rtl/router_pkt_source.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_source
//  Description : Buffers one command's payload, then streams header, payload
//                and XOR parity into router_1x3, pacing on its busy input.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_source #(
    parameter int         DEPTH    = 64,
    parameter int         IDLE_GAP = 2,
    parameter logic [1:0] BAD_ADDR = 2'b11
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_inj_err,
    input  logic       pay_valid,
    output logic       pay_ready,
    input  logic [7:0] pay_data,
    output logic [7:0] data_in,
    output logic       pkt_valid,
    input  logic       busy,
    output logic       tx_active,
    output logic       tx_done,
    output logic       cmd_err
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(IDLE_GAP - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_HDR  = 3'd2;
    localparam logic [2:0] c_PAY  = 3'd3;
    localparam logic [2:0] c_PAR  = 3'd4;
    localparam logic [2:0] c_GAP  = 3'd5;

    logic [2:0]      r_state;
    logic [1:0]      r_addr;
    logic [5:0]      r_len;
    logic            r_inj;
    logic [7:0]      r_par;
    logic [5:0]      r_cnt;
    logic [5:0]      r_rd;
    logic [c_GW-1:0] r_gap;
    logic [7:0]      r_data;
    logic            r_pkt_valid;
    logic            r_cmd_ready;
    logic            r_tx_done;
    logic            r_cmd_err;
    logic [7:0]      r_buf [DEPTH];

    logic            w_cmd_hs;
    logic            w_pay_ready;
    logic            w_pay_hs;
    logic [7:0]      w_hdr;
    logic [5:0]      w_rd_next;
    logic [7:0]      w_par_out;

    assign w_cmd_hs    = cmd_valid & r_cmd_ready;
    assign w_pay_ready = (r_state == c_LOAD) && (r_cnt != r_len);
    assign w_pay_hs    = pay_valid & w_pay_ready;
    assign w_hdr       = {r_len, r_addr};
    assign w_rd_next   = r_rd + 6'd1;
    assign w_par_out   = r_par ^ {7'b0, r_inj};

    assign cmd_ready = r_cmd_ready;
    assign pay_ready = w_pay_ready;
    assign data_in   = r_data;
    assign pkt_valid = r_pkt_valid;
    assign tx_active = (r_state != c_IDLE) && (r_state != c_LOAD);
    assign tx_done   = r_tx_done;
    assign cmd_err   = r_cmd_err;

    // Payload storage carries no reset; contents are rewritten before every read.
    always_ff @(posedge clk) begin
        if (w_pay_hs) begin
            r_buf[c_AW'(r_cnt)] <= pay_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= c_IDLE;
            r_addr      <= 2'd0;
            r_len       <= 6'd0;
            r_inj       <= 1'b0;
            r_par       <= 8'd0;
            r_cnt       <= 6'd0;
            r_rd        <= 6'd0;
            r_gap       <= '0;
            r_data      <= 8'd0;
            r_pkt_valid <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_tx_done   <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            r_cmd_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_hs) begin
                        r_addr      <= cmd_addr;
                        r_len       <= cmd_len;
                        r_inj       <= cmd_inj_err;
                        r_par       <= {cmd_len, cmd_addr};
                        r_cnt       <= 6'd0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (r_cnt == r_len) begin
                        // Rejected destinations still drain their payload before the error pulse.
                        if (r_addr == BAD_ADDR) begin
                            r_cmd_err   <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            r_state     <= c_IDLE;
                        end else begin
                            r_data      <= w_hdr;
                            r_pkt_valid <= 1'b1;
                            r_state     <= c_HDR;
                        end
                    end else if (w_pay_hs) begin
                        r_par <= r_par ^ pay_data;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                c_HDR: begin
                    if (!busy) begin
                        r_rd <= 6'd0;
                        if (r_len == 6'd0) begin
                            r_data      <= w_par_out;
                            r_pkt_valid <= 1'b0;
                            r_state     <= c_PAR;
                        end else begin
                            r_data  <= r_buf[0];
                            r_state <= c_PAY;
                        end
                    end
                end
                c_PAY: begin
                    if (!busy) begin
                        r_rd <= w_rd_next;
                        if (r_rd == (r_len - 6'd1)) begin
                            r_data      <= w_par_out;
                            r_pkt_valid <= 1'b0;
                            r_state     <= c_PAR;
                        end else begin
                            r_data <= r_buf[c_AW'(w_rd_next)];
                        end
                    end
                end
                c_PAR: begin
                    if (!busy) begin
                        r_gap   <= '0;
                        r_data  <= 8'd0;
                        r_state <= c_GAP;
                    end
                end
                c_GAP: begin
                    if (!busy) begin
                        if (r_gap == c_GAP_LAST) begin
                            r_tx_done   <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            r_state     <= c_IDLE;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
